// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD counter family: state encoding, digit width
// and the preset clamp applied to each loaded digit.
package bcd_pkg;

    localparam int DIGIT_W = 4;
    localparam logic [DIGIT_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] d);
        return (d > BCD_MAX) ? BCD_MAX : d;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter: clamped load, decrement on borrow-in,
// and borrow-out when a borrowed-into digit wraps from 0 to 9.
module bcd_down_digit
    import bcd_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [3:0]   load_digit,
    input  logic         borrow_in,
    output logic [3:0]   digit,
    output logic         borrow_out
);

    logic [DIGIT_W-1:0] digit_d;
    logic [DIGIT_W-1:0] digit_q;

    always_comb begin
        digit_d = digit_q;
        if (load) begin
            digit_d = bcd_clamp(load_digit);
        end else if (borrow_in) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : digit_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_down_timer.sv
// Multi-digit BCD countdown timer: preset load, start/pause control, one
// decrement per qualified tick and a one-cycle expired pulse on reaching zero.
module bcd_down_timer
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_value,
    input  logic                  start,
    input  logic                  pause,
    input  logic                  tick,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  zero,
    output logic                  expired
);

    localparam logic [DIGIT_W*DIGITS-1:0] COUNT_ONE = (DIGIT_W*DIGITS)'(1);

    state_t state_d;
    state_t state_q;
    logic   en;

    logic [DIGITS:0] borrow;
    logic            borrow_unused;

    assign borrow[0]     = en;
    assign borrow_unused = borrow[DIGITS];

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        bcd_down_digit u_digit (
            .clk        (clk),
            .reset      (reset),
            .load       (load),
            .load_digit (load_value[DIGIT_W*i +: DIGIT_W]),
            .borrow_in  (borrow[i]),
            .digit      (count[DIGIT_W*i +: DIGIT_W]),
            .borrow_out (borrow[i+1])
        );
    end

    // A tick is consumed only in RUN with no pause/load/reset competing, and
    // never on an all-zero count, so the counter cannot wrap below zero.
    always_comb begin
        state_d = state_q;
        en      = 1'b0;
        if (load) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (start && !zero) state_d = RUN;
                RUN: begin
                    if (pause) begin
                        state_d = HOLD;
                    end else if (tick && !zero && !reset) begin
                        en = 1'b1;
                        if (count == COUNT_ONE) state_d = DONE;
                    end
                end
                HOLD: if (start && !zero) state_d = RUN;
                DONE: state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    assign running = (state_q == RUN);
    assign expired = (state_q == DONE);
    assign zero    = (count == '0);

endmodule

// File: tb/tb_bcd_down_timer.sv
// Scoreboard bench for bcd_down_timer: a decimal reference model predicts each
// cycle's outputs; a monitor pops and compares them one cycle later.
module tb_bcd_down_timer;

    localparam int DIGITS = 4;
    localparam int W      = 4 * DIGITS;

    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HOLD = 2;
    localparam int M_DONE = 3;

    logic         clk = 1'b0;
    logic         reset;
    logic         load;
    logic [W-1:0] load_value;
    logic         start;
    logic         pause;
    logic         tick;
    logic [W-1:0] count;
    logic         running;
    logic         zero;
    logic         expired;

    always #5 clk = ~clk;

    bcd_down_timer #(.DIGITS(DIGITS)) dut (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (load_value),
        .start      (start),
        .pause      (pause),
        .tick       (tick),
        .count      (count),
        .running    (running),
        .zero       (zero),
        .expired    (expired)
    );

    typedef struct packed {
        logic [W-1:0] count;
        logic         running;
        logic         zero;
        logic         expired;
    } exp_t;

    exp_t sb[$];
    int   m_cnt   = 0;
    int   m_st    = M_IDLE;
    int   n_pass  = 0;
    int   n_total = 0;
    int   n_mon   = 0;

    function automatic int preset_value(input logic [W-1:0] v);
        int sum = 0;
        int pw  = 1;
        for (int i = 0; i < DIGITS; i++) begin
            int d = int'(v[4*i +: 4]);
            if (d > 9) d = 9;
            sum += d * pw;
            pw  *= 10;
        end
        return sum;
    endfunction

    function automatic logic [W-1:0] to_bcd(input int v);
        logic [W-1:0] r = '0;
        int x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s sample %0d: got %h, expected %h", name, n_mon, got, exp);
    endtask

    task automatic step(input logic r, input logic l, input logic [W-1:0] lv,
                        input logic s, input logic p, input logic t);
        exp_t e;
        reset = r; load = l; load_value = lv; start = s; pause = p; tick = t;
        if (r) begin
            m_cnt = 0;
            m_st  = M_IDLE;
        end else if (l) begin
            m_cnt = preset_value(lv);
            m_st  = M_IDLE;
        end else if (m_st == M_DONE) begin
            m_st = M_IDLE;
        end else if (m_st == M_IDLE || m_st == M_HOLD) begin
            if (s && m_cnt != 0) m_st = M_RUN;
        end else if (p) begin
            m_st = M_HOLD;
        end else if (t && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_st = M_DONE;
        end
        e.count   = to_bcd(m_cnt);
        e.running = (m_st == M_RUN);
        e.zero    = (m_cnt == 0);
        e.expired = (m_st == M_DONE);
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, 0, 0, 0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_mon++;
                check("count",   count,          e.count);
                check("running", W'(running),    W'(e.running));
                check("zero",    W'(zero),       W'(e.zero));
                check("expired", W'(expired),    W'(e.expired));
            end
        end
    end

    initial begin : stimulus
        reset = 1'b1; load = 1'b0; load_value = '0; start = 1'b0; pause = 1'b0; tick = 1'b0;
        step(1, 0, '0, 0, 0, 0);
        idle(1);

        // borrow chain
        step(0, 1, 16'h0102, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, '0, 0, 0, 1);
        idle(1);

        // expiry with tick held
        step(0, 1, 16'h0002, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, '0, 0, 0, 1);
        idle(1);

        // pause / resume
        step(0, 1, 16'h0051, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 1, 1);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 1, 1, 0);
        step(0, 0, '0, 1, 1, 1);
        idle(1);

        // clamp and empty start
        step(0, 1, 16'h1A3F, 0, 0, 0);
        idle(1);
        step(0, 1, 16'h0000, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        idle(2);

        // load during DONE
        step(0, 1, 16'h0001, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 1, 16'h0003, 0, 0, 0);
        idle(2);

        // reset mid-run
        step(0, 1, 16'h0500, 0, 0, 0);
        step(0, 0, '0, 1, 0, 0);
        step(0, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        step(1, 0, '0, 0, 0, 1);
        step(0, 0, '0, 0, 0, 1);
        idle(1);

        // randomized traffic; small presets make expiry frequent
        for (int i = 0; i < 800; i++) begin
            logic         r, l, s, p, t;
            logic [W-1:0] lv;
            r  = ($urandom % 100) == 0;
            l  = ($urandom % 16) == 0;
            s  = ($urandom % 6) == 0;
            p  = ($urandom % 10) == 0;
            t  = ($urandom % 4) != 0;
            case ($urandom % 3)
                0: lv = W'($urandom);
                1: lv = {8'h00, 8'($urandom)};
                default: lv = {12'h000, 4'($urandom % 4)};
            endcase
            step(r, l, lv, s, p, t);
        end
        idle(2);

        repeat (3) @(posedge clk);
        #3;
        n_total++;
        if (sb.size() == 0) n_pass++;
        else $display("FAIL drain: %0d expected samples left unchecked, required 0", sb.size());

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
